// File: rtl/mult_sched_pkg.sv
// Shared constants, FSM state encoding and BCD helper for the
// two-requester shift-add multiplier scheduler.
package mult_sched_pkg;

  localparam int OPW  = 3;
  localparam int PW   = 2 * OPW;
  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Products never exceed 49, so both digits fit in one nibble each.
  function automatic logic [7:0] bcd_split(input logic [PW-1:0] p);
    bcd_split = {4'(p / 6'd10), 4'(p % 6'd10)};
  endfunction

endpackage

// File: rtl/mult_scheduler_if.sv
// Request/result bus of the multiplier scheduler; slave is the scheduler,
// master is whoever issues requests and consumes results.
interface mult_scheduler_if;
  import mult_sched_pkg::*;

  logic [NREQ-1:0]     req_valid;
  logic [NREQ*OPW-1:0] req_a;
  logic [NREQ*OPW-1:0] req_b;
  logic [NREQ-1:0]     req_ready;
  logic                res_valid;
  logic                res_ready;
  logic                res_id;
  logic [PW-1:0]       res_p;
  logic [3:0]          res_tens;
  logic [3:0]          res_ones;
  logic                busy;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_p, res_tens, res_ones, busy
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_p, res_tens, res_ones, busy
  );

endinterface

// File: rtl/mult_seq_core.sv
// Sequential shift-add multiplier: one partial product per clock, three
// clocks per operation; done_o marks the clock whose sum is the product.
module mult_seq_core
  import mult_sched_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] b_i,
  output logic           done_o,
  output logic [PW-1:0]  prod_o
);

  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  sum_s;
  logic [1:0]     cnt_q, cnt_d;
  logic           run_q, run_d;

  // Accumulator plus the partial product selected by the current bit of B
  always_comb begin
    sum_s = acc_q;
    if (b_q[cnt_q]) begin
      sum_s = acc_q + ({{(PW-OPW){1'b0}}, a_q} << cnt_q);
    end else begin
      sum_s = acc_q;
    end
  end

  // Operand capture on start, then iterations 0..2 while running
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = {PW{1'b0}};
      cnt_d = 2'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = sum_s;
      if (cnt_q == 2'd2) begin
        cnt_d = 2'd0;
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Core state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= {OPW{1'b0}};
      b_q   <= {OPW{1'b0}};
      acc_q <= {PW{1'b0}};
      cnt_q <= 2'd0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == 2'd2);
  assign prod_o = sum_s;

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin arbiter for two requesters in front of a shared 3x3 shift-add
// multiplier; results are held with their BCD split until consumed.
module mult_scheduler #(
  parameter int OPW = 3,
  parameter int PW  = 6
) (
  input logic             clk,
  input logic             rst_n,
  mult_scheduler_if.slave bus
);
  import mult_sched_pkg::*;

  state_e         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic           cur_id_q, cur_id_d;
  logic           res_id_q, res_id_d;
  logic [PW-1:0]  res_p_q, res_p_d;
  logic [3:0]     res_tens_q, res_tens_d;
  logic [3:0]     res_ones_q, res_ones_d;
  logic           gnt_s;
  logic           hs_s;
  logic [1:0]     req_ready_s;
  logic [OPW-1:0] a_sel_s, b_sel_s;
  logic           core_done_s;
  logic [PW-1:0]  core_prod_s;
  logic [7:0]     bcd_s;

  // Grant selection and operand mux; ready is masked during reset
  always_comb begin
    gnt_s = 1'b0;
    if (bus.req_valid == 2'b11) begin
      gnt_s = ptr_q;
    end else if (bus.req_valid == 2'b10) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
    if (gnt_s) begin
      a_sel_s = bus.req_a[2*OPW-1:OPW];
      b_sel_s = bus.req_b[2*OPW-1:OPW];
    end else begin
      a_sel_s = bus.req_a[OPW-1:0];
      b_sel_s = bus.req_b[OPW-1:0];
    end
    hs_s = rst_n && (state_q == ST_IDLE) && bus.req_valid[gnt_s];
    if (hs_s) begin
      req_ready_s = gnt_s ? 2'b10 : 2'b01;
    end else begin
      req_ready_s = 2'b00;
    end
  end

  mult_seq_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (hs_s),
    .a_i     (a_sel_s),
    .b_i     (b_sel_s),
    .done_o  (core_done_s),
    .prod_o  (core_prod_s)
  );

  assign bcd_s = bcd_split(core_prod_s);

  // FSM next state, pointer update and result register loads
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_id_d   = cur_id_q;
    res_id_d   = res_id_q;
    res_p_d    = res_p_q;
    res_tens_d = res_tens_q;
    res_ones_d = res_ones_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          cur_id_d = gnt_s;
          ptr_d    = ~gnt_s;
          state_d  = ST_CALC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (core_done_s) begin
          res_p_d    = core_prod_s;
          res_tens_d = bcd_s[7:4];
          res_ones_d = bcd_s[3:0];
          res_id_d   = cur_id_q;
          state_d    = ST_DONE;
        end else begin
          state_d    = ST_CALC;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler state and result holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      cur_id_q   <= 1'b0;
      res_id_q   <= 1'b0;
      res_p_q    <= {PW{1'b0}};
      res_tens_q <= 4'd0;
      res_ones_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_id_q   <= cur_id_d;
      res_id_q   <= res_id_d;
      res_p_q    <= res_p_d;
      res_tens_q <= res_tens_d;
      res_ones_q <= res_ones_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.res_id    = res_id_q;
  assign bus.res_p     = res_p_q;
  assign bus.res_tens  = res_tens_q;
  assign bus.res_ones  = res_ones_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Self-checking bench for mult_scheduler: directed vector table, hand-written
// stall/reset/back-to-back sequences and randomized traffic against a model.
module tb_mult_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  mult_scheduler_if bus ();

  mult_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] v;
    logic [2:0] a0;
    logic [2:0] b0;
    logic [2:0] a1;
    logic [2:0] b1;
    int         eid;
    int         ep;
    int         et;
    int         eo;
  } vec_t;

  vec_t tbl[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One full transaction: handshake, 3-clock latency, optional stall, consume.
  task automatic run_txn(input logic [1:0] v, input logic [2:0] a0, input logic [2:0] b0,
                         input logic [2:0] a1, input logic [2:0] b1, input int eid,
                         input int ep, input int et, input int eo, input int stall);
    bus.req_valid = v;
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
    bus.res_ready = 1'b0;
    #1;
    chk("grant_ready", int'(bus.req_ready), 1 << eid);
    chk("idle_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    bus.req_valid = 2'($urandom_range(3, 0));
    bus.req_a     = 6'($urandom);
    bus.req_b     = 6'($urandom);
    #1;
    chk("calc_busy", int'(bus.busy), 1);
    chk("calc_ready", int'(bus.req_ready), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("early_valid", int'(bus.res_valid), 0);
    @(posedge clk); #1;
    chk("res_valid", int'(bus.res_valid), 1);
    chk("res_p", int'(bus.res_p), ep);
    chk("res_tens", int'(bus.res_tens), et);
    chk("res_ones", int'(bus.res_ones), eo);
    chk("res_id", int'(bus.res_id), eid);
    for (int s = 0; s < stall; s++) begin
      bus.req_valid = 2'($urandom_range(3, 0));
      bus.req_a     = 6'($urandom);
      @(posedge clk); #1;
      chk("stall_valid", int'(bus.res_valid), 1);
      chk("stall_p", int'(bus.res_p), ep);
      chk("stall_ones", int'(bus.res_ones), eo);
      chk("stall_ready", int'(bus.req_ready), 0);
      chk("stall_busy", int'(bus.busy), 1);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.req_valid = 2'b00;
    chk("consumed_valid", int'(bus.res_valid), 0);
    chk("consumed_busy", int'(bus.busy), 0);
    chk("retained_p", int'(bus.res_p), ep);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int mptr;
    int g;
    int pa;
    int pb;
    int p;
    int last;
    int seen;
    logic [1:0] rv;
    logic [2:0] ra0, rb0, ra1, rb1;

    checks        = 0;
    errors        = 0;
    cyc           = 0;
    rst_n         = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_a     = 6'd0;
    bus.req_b     = 6'd0;
    bus.res_ready = 1'b0;

    tbl[0] = '{2'b11, 3'd3, 3'd5, 3'd6, 3'd2, 0, 15, 1, 5};
    tbl[1] = '{2'b11, 3'd3, 3'd5, 3'd6, 3'd2, 1, 12, 1, 2};
    tbl[2] = '{2'b01, 3'd7, 3'd7, 3'd0, 3'd0, 0, 49, 4, 9};
    tbl[3] = '{2'b10, 3'd1, 3'd1, 3'd0, 3'd5, 1,  0, 0, 0};
    tbl[4] = '{2'b11, 3'd4, 3'd4, 3'd5, 3'd5, 0, 16, 1, 6};
    tbl[5] = '{2'b01, 3'd2, 3'd3, 3'd7, 3'd7, 0,  6, 0, 6};
    tbl[6] = '{2'b11, 3'd1, 3'd1, 3'd7, 3'd6, 1, 42, 4, 2};
    tbl[7] = '{2'b10, 3'd0, 3'd0, 3'd7, 3'd1, 1,  7, 0, 7};

    #1;
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_valid", int'(bus.res_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_p", int'(bus.res_p), 0);
    chk("rst_id", int'(bus.res_id), 0);
    bus.req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
              tbl[i].eid, tbl[i].ep, tbl[i].et, tbl[i].eo, 0);
    end

    // Result held for ten cycles with the consumer stalled
    run_txn(2'b10, 3'd0, 3'd0, 3'd5, 3'd5, 1, 25, 2, 5, 10);

    // Reset in the second CALC cycle abandons the operation
    bus.req_valid = 2'b01;
    bus.req_a     = {3'd0, 3'd4};
    bus.req_b     = {3'd0, 3'd6};
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", int'(bus.res_valid), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_ready", int'(bus.req_ready), 0);
    chk("abort_p", int'(bus.res_p), 0);
    chk("abort_tens", int'(bus.res_tens), 0);
    chk("abort_ones", int'(bus.res_ones), 0);
    chk("abort_id", int'(bus.res_id), 0);
    bus.req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.res_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    run_txn(2'b01, 3'd2, 3'd3, 3'd0, 3'd0, 0, 6, 0, 6, 0);

    // Back-to-back grants to requester 0 with the consumer always ready
    bus.req_valid = 2'b01;
    bus.req_a     = {3'd0, 3'd3};
    bus.req_b     = {3'd0, 3'd3};
    bus.res_ready = 1'b1;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = 0;
      do begin
        @(posedge clk); #1;
        w++;
      end while (!bus.res_valid && w < 12);
      chk("b2b_seen", int'(bus.res_valid), 1);
      chk("b2b_p", int'(bus.res_p), 9);
      chk("b2b_id", int'(bus.res_id), 0);
      if (k > 0) chk("b2b_gap", cyc - last, 5);
      last = cyc;
    end
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;

    // Randomized traffic against the arbitration/arithmetic model
    do_reset();
    mptr = 0;
    for (int n = 0; n < 40; n++) begin
      rv  = 2'($urandom_range(3, 1));
      ra0 = 3'($urandom);
      rb0 = 3'($urandom);
      ra1 = 3'($urandom);
      rb1 = 3'($urandom);
      g   = (rv == 2'b11) ? mptr : ((rv == 2'b10) ? 1 : 0);
      pa  = (g == 1) ? int'(ra1) : int'(ra0);
      pb  = (g == 1) ? int'(rb1) : int'(rb0);
      p   = pa * pb;
      run_txn(rv, ra0, rb0, ra1, rb1, g, p, p / 10, p % 10, $urandom_range(2, 0));
      mptr = 1 - g;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter OPW, default 3, operand width in bits; only 3 is supported.
REQ-002 Parameter PW, default 6, product width (2*OPW).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester request strobe; bit i = requester i.
REQ-006 req_a  input  6  packed operands A; bits [3i+2:3i] belong to requester i.
REQ-007 req_b  input  6  packed operands B; same packing as req_a.
REQ-008 req_ready  output  2  per-requester accept; at most one bit high.
REQ-009 res_valid  output  1  result holding registers valid.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_id  output  1  index of requester that owns the result.
REQ-012 res_p  output  6  unsigned product A*B.
REQ-013 res_tens  output  4  BCD tens digit of res_p (0-4).
REQ-014 res_ones  output  4  BCD ones digit of res_p (0-9).
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, CALC, DONE; reset state IDLE.
REQ-017 In IDLE, req_ready[g] SHALL be high only when req_valid[g]=1 and g is the grant; all other req_ready bits low; req_ready low in CALC and DONE.
REQ-018 Grant: if only one req_valid bit is high, it wins; if both, the requester indicated by the round-robin pointer wins.
REQ-019 Pointer SHALL update on each accepted handshake to the requester other than the one just served; it is unchanged when no handshake occurs.
REQ-020 On handshake (req_valid[g]&req_ready[g]) at edge E, the block SHALL capture A, B and g, clear the accumulator and enter CALC.
REQ-021 CALC SHALL run exactly 3 iterations at edges E+1..E+3; iteration k adds (A<<k) to the 6-bit accumulator when B[k]=1; no overflow is possible (max 49).
REQ-022 At edge E+3 res_p, res_id, res_tens, res_ones SHALL be loaded and state SHALL become DONE; res_valid rises at E+3 (latency 3 clocks, independent of operand values).
REQ-023 res_tens/res_ones SHALL equal res_p/10 and res_p%10, registered together with res_p.
REQ-024 In DONE, res_valid SHALL remain high and all result outputs SHALL stay stable until res_valid&res_ready is sampled; then state returns to IDLE at that edge and res_valid falls.
REQ-025 No new request SHALL be accepted in the cycle the result is consumed; earliest next handshake is the following cycle (IDLE).
REQ-026 Changes of req_a/req_b/req_valid during CALC or DONE SHALL have no effect on the in-flight result.
REQ-027 res_p and BCD outputs SHALL retain the last result after consumption until the next DONE load.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, pointer 0, res_valid 0, req_ready 0, busy 0, res_id 0, res_p 0, res_tens 0, res_ones 0, accumulator 0.
REQ-029 Reset during CALC or DONE SHALL abandon the operation with no result ever presented; operation resumes from the first rising edge after rst_n high.

Structure
REQ-030 Package mult_sched_pkg SHALL hold OPW, PW, the number of requesters (2) and the FSM state encoding.
REQ-031 The shift-add iteration (operand registers, accumulator, iteration counter 0-2) SHALL be one sub-module mult_seq_core with start/done handshake to the FSM; arbitration, result registers and BCD split remain in mult_scheduler.

Verification
REQ-032 Req0 A=7,B=7 alone -> req_ready=01 for 1 cycle; res_valid 3 clocks later, res_p=49, res_tens=4, res_ones=9, res_id=0.
REQ-033 Both valid from reset, req0 3*5, req1 6*2 -> req0 served first (res_p=15, tens 1, ones 5), then req1 (res_p=12, res_id=1).
REQ-034 Req1 A=0,B=5 -> res_p=0, tens 0, ones 0 after exactly 3 clocks.
REQ-035 res_ready held low 10 cycles in DONE -> res_valid and result unchanged, req_ready=00, busy=1 throughout.
REQ-036 rst_n asserted at second CALC cycle of 4*6 -> outputs zero immediately; no res_valid after release; next request 2*3 gives res_p=6.
REQ-037 Req0 held valid continuously with req1 idle, res_ready=1 -> back-to-back grants to req0, one result every 5 cycles, res_id=0 each time.
